// File: rtl/fp_issue_sched.sv
// Issue/writeback scheduler for the FP unit: FMA pipe, single-cycle ops and one iterative divider share one writeback port.
// Optional perf counters (stall_cnt, div_wait_cnt) are built when FP_ISSUE_SCHED_PERF_EN is defined.
module fp_issue_sched #(
  parameter int FMA_LAT = 4,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_class,
  input  logic [TAG_W-1:0] req_tag,
  output logic             unit_start,
  input  logic             div_ready,
  output logic             div_ack,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [1:0]       wb_class,
  output logic             busy
`ifdef FP_ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      div_wait_cnt
`endif
);

  localparam logic [1:0] CLS_SINGLE = 2'd0;
  localparam logic [1:0] CLS_FMA    = 2'd1;
  localparam logic [1:0] CLS_DIV    = 2'd2;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // Stages 1..FMA_LAT-1; the final stage is the writeback register itself.
  stage_t [FMA_LAT-1:1] sr;
  logic                 div_busy;
  logic [TAG_W-1:0]     div_tag;

  logic is_fma, is_div, is_single, accept, fma_due, single_acc, div_sel, any_sr;

  always_comb begin
    is_fma    = (req_class == CLS_FMA);
    is_div    = (req_class == CLS_DIV);
    is_single = !is_fma && !is_div;
    fma_due   = sr[FMA_LAT-1].vld;
    req_ready = 1'b0;
    if (rst_n && !clear) begin
      if (is_fma)      req_ready = 1'b1;
      else if (is_div) req_ready = !div_busy;
      else             req_ready = !fma_due;
    end
    accept     = req_valid & req_ready;
    unit_start = accept;
    single_acc = accept & is_single;
    // Divider only takes the port when nothing higher-priority lands next cycle.
    div_sel    = div_ready & div_busy & ~div_ack & ~fma_due & ~single_acc;
    any_sr     = 1'b0;
    for (int k = 1; k < FMA_LAT; k++) any_sr |= sr[k].vld;
    busy       = any_sr | wb_valid | div_busy;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else begin
      sr[1].vld <= accept & is_fma;
      sr[1].tag <= req_tag;
      for (int k = 2; k < FMA_LAT; k++) sr[k] <= sr[k-1];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_class <= '0;
      div_ack  <= 1'b0;
    end else if (clear) begin
      wb_valid <= 1'b0;
      div_ack  <= 1'b0;
    end else begin
      wb_valid <= fma_due | single_acc | div_sel;
      div_ack  <= div_sel;
      if (fma_due) begin
        wb_tag   <= sr[FMA_LAT-1].tag;
        wb_class <= CLS_FMA;
      end else if (single_acc) begin
        wb_tag   <= req_tag;
        wb_class <= CLS_SINGLE;
      end else if (div_sel) begin
        wb_tag   <= div_tag;
        wb_class <= CLS_DIV;
      end
    end
  end

  // div_busy stays set through the ack cycle so a new fdiv cannot overlap it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      div_busy <= 1'b0;
      div_tag  <= '0;
    end else if (clear) begin
      div_busy <= 1'b0;
    end else if (accept && is_div) begin
      div_busy <= 1'b1;
      div_tag  <= req_tag;
    end else if (div_ack) begin
      div_busy <= 1'b0;
    end
  end

`ifdef FP_ISSUE_SCHED_PERF_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      div_wait_cnt <= '0;
    end else begin
      stall_cnt    <= stall_cnt + 32'(req_valid & ~req_ready);
      div_wait_cnt <= div_wait_cnt + 32'(div_ready & ~div_ack);
    end
  end
`endif

endmodule

// File: tb/tb_fp_issue_sched.sv
// Bench for fp_issue_sched: directed scenarios plus a randomized run against a writeback-schedule model.
module tb_fp_issue_sched;
  localparam int L  = 4;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_class = '0;
  logic [TW-1:0] req_tag = '0;
  logic          div_ready = 1'b0;
  logic          req_ready, unit_start, div_ack, wb_valid, busy;
  logic [TW-1:0] wb_tag;
  logic [1:0]    wb_class;
`ifdef FP_ISSUE_SCHED_PERF_EN
  logic [31:0]   stall_cnt, div_wait_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  fp_issue_sched #(.FMA_LAT(L), .TAG_W(TW)) dut (
    .clock(clock), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class), .req_tag(req_tag),
    .unit_start(unit_start), .div_ready(div_ready), .div_ack(div_ack),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_class(wb_class), .busy(busy)
`ifdef FP_ISSUE_SCHED_PERF_EN
    , .stall_cnt(stall_cnt), .div_wait_cnt(div_wait_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [TW-1:0] t);
    req_valid = v;
    req_class = c;
    req_tag   = t;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, '0);
    clear = 1'b0;
    div_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'd1, 5'd3);
    @(negedge clock);
    nvec++; if (wb_valid !== 1'b0 || wb_tag !== '0 || wb_class !== 2'd0) begin nerr++;
      $display("FAIL reset_wb got v=%0b tag=%0d cls=%0d want 0/0/0", wb_valid, wb_tag, wb_class); end
    nvec++; if (div_ack !== 1'b0 || busy !== 1'b0) begin nerr++;
      $display("FAIL reset_ack_busy got ack=%0b busy=%0b want 0/0", div_ack, busy); end
    nvec++; if (req_ready !== 1'b0 || unit_start !== 1'b0) begin nerr++;
      $display("FAIL reset_ready got ready=%0b start=%0b want 0/0", req_ready, unit_start); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic ev;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c < 3) drive(1'b1, 2'd1, 5'(c + 1)); else drive(1'b0, 2'd0, '0);
      @(negedge clock);
      ev = (c >= 4 && c <= 6);
      if (c < 3) begin nvec++; if (req_ready !== 1'b1) begin nerr++;
        $display("FAIL b2b_ready c=%0d got %0b want 1", c, req_ready); end end
      nvec++; if (wb_valid !== ev) begin nerr++;
        $display("FAIL b2b_wb_valid c=%0d got %0b want %0b", c, wb_valid, ev); end
      if (ev) begin nvec++; if (wb_tag !== 5'(c - 3) || wb_class !== 2'd1) begin nerr++;
        $display("FAIL b2b_wb c=%0d got tag=%0d cls=%0d want tag=%0d cls=1", c, wb_tag, wb_class, c - 3); end end
      tick();
    end
  endtask

  task automatic test_single_hazard();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) drive(1'b1, 2'd1, 5'd7);
      else if (c == 3 || c == 4) drive(1'b1, 2'd0, 5'd9);
      else drive(1'b0, 2'd0, '0);
      @(negedge clock);
      if (c == 3) begin nvec++; if (req_ready !== 1'b0 || unit_start !== 1'b0) begin nerr++;
        $display("FAIL hazard_block got ready=%0b start=%0b want 0/0", req_ready, unit_start); end end
      if (c == 4) begin nvec++; if (req_ready !== 1'b1 || unit_start !== 1'b1) begin nerr++;
        $display("FAIL hazard_accept got ready=%0b start=%0b want 1/1", req_ready, unit_start); end end
      nvec++; if (wb_valid !== (c == 4 || c == 5)) begin nerr++;
        $display("FAIL hazard_wb_valid c=%0d got %0b", c, wb_valid); end
      if (c == 4) begin nvec++; if (wb_tag !== 5'd7 || wb_class !== 2'd1) begin nerr++;
        $display("FAIL hazard_wb_fma got tag=%0d cls=%0d want 7/1", wb_tag, wb_class); end end
      if (c == 5) begin nvec++; if (wb_tag !== 5'd9 || wb_class !== 2'd0) begin nerr++;
        $display("FAIL hazard_wb_single got tag=%0d cls=%0d want 9/0", wb_tag, wb_class); end end
`ifdef FP_ISSUE_SCHED_PERF_EN
      if (c == 7) begin nvec++; if (stall_cnt !== 32'd1) begin nerr++;
        $display("FAIL hazard_stall_cnt got %0d want 1", stall_cnt); end end
`endif
      tick();
    end
  endtask

  task automatic test_div();
    logic ev, ea, er;
    logic [TW-1:0] et;
    logic [1:0] ec;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) drive(1'b1, 2'd2, 5'd4);
      else if (c == 1) drive(1'b1, 2'd1, 5'd10);
      else if (c <= 7) drive(1'b1, 2'd2, 5'd5);
      else drive(1'b0, 2'd0, '0);
      div_ready = (c == 5 || c == 6 || c == 8 || c == 9);
      @(negedge clock);
      ev = (c == 5 || c == 6 || c == 9);
      ea = (c == 6 || c == 9);
      et = (c == 5) ? 5'd10 : (c == 6) ? 5'd4 : 5'd5;
      ec = (c == 5) ? 2'd1 : 2'd2;
      er = !(c >= 2 && c <= 6);
      if (c <= 7) begin nvec++; if (req_ready !== er) begin nerr++;
        $display("FAIL div_ready_gate c=%0d got %0b want %0b", c, req_ready, er); end end
      nvec++; if (wb_valid !== ev || div_ack !== ea) begin nerr++;
        $display("FAIL div_wb c=%0d got v=%0b ack=%0b want v=%0b ack=%0b", c, wb_valid, div_ack, ev, ea); end
      if (ev) begin nvec++; if (wb_tag !== et || wb_class !== ec) begin nerr++;
        $display("FAIL div_wb_data c=%0d got tag=%0d cls=%0d want tag=%0d cls=%0d", c, wb_tag, wb_class, et, ec); end end
`ifdef FP_ISSUE_SCHED_PERF_EN
      if (c == 7) begin nvec++; if (div_wait_cnt !== 32'd1) begin nerr++;
        $display("FAIL div_wait_cnt got %0d want 1", div_wait_cnt); end end
`endif
      if (c == 11) begin nvec++; if (busy !== 1'b0) begin nerr++;
        $display("FAIL div_idle_busy got %0b want 0", busy); end end
      tick();
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) drive(1'b1, 2'd2, 5'd20);
      else if (c <= 4) drive(1'b1, 2'd1, 5'(20 + c));
      else drive(1'b0, 2'd0, '0);
      clear = (c == 4);
      div_ready = (c >= 6 && c <= 8);
      @(negedge clock);
      if (c == 4) begin nvec++; if (req_ready !== 1'b0 || unit_start !== 1'b0 || busy !== 1'b1) begin nerr++;
        $display("FAIL clear_cycle got ready=%0b start=%0b busy=%0b want 0/0/1", req_ready, unit_start, busy); end end
      if (c >= 5) begin nvec++; if (wb_valid !== 1'b0 || div_ack !== 1'b0 || busy !== 1'b0) begin nerr++;
        $display("FAIL clear_after c=%0d got v=%0b ack=%0b busy=%0b want 0/0/0", c, wb_valid, div_ack, busy); end end
      tick();
    end
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1'b1, 2'd1, 5'd1);
      else if (c == 1) drive(1'b1, 2'd2, 5'd3);
      else drive(1'b1, 2'd1, 5'd2);
      @(negedge clock);
      if (c == 4) begin nvec++; if (wb_valid !== 1'b1 || wb_tag !== 5'd1 || busy !== 1'b1) begin nerr++;
        $display("FAIL areset_pre got v=%0b tag=%0d busy=%0b want 1/1/1", wb_valid, wb_tag, busy); end end
      if (c < 4) tick();
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (wb_valid !== 1'b0 || div_ack !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin nerr++;
      $display("FAIL areset_now got v=%0b ack=%0b busy=%0b ready=%0b want 0/0/0/0", wb_valid, div_ack, busy, req_ready); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) drive(1'b1, 2'd1, 5'd6); else drive(1'b0, 2'd0, '0);
      @(negedge clock);
      nvec++; if (wb_valid !== (c == 4)) begin nerr++;
        $display("FAIL areset_post_wb c=%0d got %0b want %0b", c, wb_valid, c == 4); end
      if (c == 4) begin nvec++; if (wb_tag !== 5'd6 || wb_class !== 2'd1) begin nerr++;
        $display("FAIL areset_post_tag got tag=%0d cls=%0d want 6/1", wb_tag, wb_class); end end
      tick();
    end
  endtask

  // Model: per-cycle writeback schedule, indexed by absolute cycle modulo 16.
  logic          ev [16];
  logic [TW-1:0] et [16];
  logic [1:0]    ec [16];
  logic          ea [16];

  task automatic test_random();
    bit div_out, ack_seen, er, eb, acc, is_f, is_d, d_now, a_now;
    logic [TW-1:0] div_t;
    int wait_ctr, s, n;
`ifdef FP_ISSUE_SCHED_PERF_EN
    int stall_m = 0;
    int dwait_m = 0;
`endif
    div_out = 0; ack_seen = 0; div_t = '0; wait_ctr = 0;
    for (int i = 0; i < 16; i++) begin ev[i] = 0; et[i] = '0; ec[i] = '0; ea[i] = 0; end
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 5'($urandom));
      if (ack_seen) div_ready = 1'b0;
      else if (div_out) begin
        if (!div_ready) begin if (wait_ctr == 0) div_ready = 1'b1; else wait_ctr--; end
      end else div_ready = ($urandom_range(0, 31) == 0);
      ack_seen = 0;
      @(negedge clock);
      s = cyc % 16;
      n = (cyc + 1) % 16;
      is_f = (req_class == 2'd1);
      is_d = (req_class == 2'd2);
      er = !clear && (is_f ? 1'b1 : is_d ? !div_out : !ev[n]);
      eb = div_out;
      for (int k = 0; k < L; k++) eb |= ev[(cyc + k) % 16];
      nvec++; if (req_ready !== er || unit_start !== (req_valid & er)) begin nerr++;
        $display("FAIL rnd_ready cyc=%0d got ready=%0b start=%0b want %0b/%0b", cyc, req_ready, unit_start, er, req_valid & er); end
      nvec++; if (wb_valid !== ev[s] || div_ack !== ea[s] || busy !== eb) begin nerr++;
        $display("FAIL rnd_ctl cyc=%0d got v=%0b ack=%0b busy=%0b want %0b/%0b/%0b", cyc, wb_valid, div_ack, busy, ev[s], ea[s], eb); end
      if (ev[s]) begin nvec++; if (wb_tag !== et[s] || wb_class !== ec[s]) begin nerr++;
        $display("FAIL rnd_wb cyc=%0d got tag=%0d cls=%0d want %0d/%0d", cyc, wb_tag, wb_class, et[s], ec[s]); end end
`ifdef FP_ISSUE_SCHED_PERF_EN
      stall_m += int'(req_valid & !er);
      dwait_m += int'(div_ready & !ea[s]);
`endif
      d_now = div_out;
      a_now = ea[s];
      if (a_now) begin ack_seen = 1; div_out = 0; end
      ev[s] = 0; ea[s] = 0;
      if (clear) begin
        for (int i = 0; i < 16; i++) begin ev[i] = 0; ea[i] = 0; end
        div_out = 0;
      end else begin
        acc = req_valid && er;
        if (acc && is_f) begin ev[(cyc + L) % 16] = 1; et[(cyc + L) % 16] = req_tag; ec[(cyc + L) % 16] = 2'd1; end
        else if (acc && !is_d) begin ev[n] = 1; et[n] = req_tag; ec[n] = 2'd0; end
        else if (acc && is_d) begin div_out = 1; div_t = req_tag; wait_ctr = $urandom_range(0, 10); end
        if (d_now && !a_now && div_ready && !ev[n]) begin
          ev[n] = 1; et[n] = div_t; ec[n] = 2'd2; ea[n] = 1;
        end
      end
      tick();
    end
    clear = 1'b0;
    div_ready = 1'b0;
    drive(1'b0, 2'd0, '0);
`ifdef FP_ISSUE_SCHED_PERF_EN
    @(negedge clock);
    nvec++; if (stall_cnt !== 32'(stall_m) || div_wait_cnt !== 32'(dwait_m)) begin nerr++;
      $display("FAIL rnd_perf got stall=%0d wait=%0d want %0d/%0d", stall_cnt, div_wait_cnt, stall_m, dwait_m); end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_hazard();
    test_div();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
